// File: rtl/pwm_capture.sv
// PWM capture: measures the period and high time of an asynchronous PWM line and flags a stuck line.
// Optional glitch filter between synchroniser and edge detect: define PWM_CAP_FILTER_EN.
module pwm_capture #(
    parameter int              CNT_W    = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(5000000),
    parameter int              FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_t,
    output logic             valid,
    output logic             stuck,
    output logic             level,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEAS_HI = 2'd1,
        MEAS_LO = 2'd2
    } state_t;

    if (TIMEOUT == '1) begin : g_bad_timeout
        $error("TIMEOUT must be below the counter saturation value");
    end
    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("FILT_LEN must be at least 1");
    end

    state_t           state, state_nxt;
    logic             sync1, s, lvl, lvl_d;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, hi;
    logic             capture, latch_hi, timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            s     <= sync1;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);
    logic [FC_W-1:0] filt_cnt;
    logic            filt_lvl;

    // Level flips only after FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_lvl <= 1'b0;
            filt_cnt <= '0;
        end else if (s == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
            filt_lvl <= s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end
    assign lvl = filt_lvl;
`else
    assign lvl = s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_d <= 1'b0;
        else        lvl_d <= lvl;
    end

    assign rise      = lvl & ~lvl_d;
    assign fall      = ~lvl & lvl_d;
    assign level     = lvl;
    assign state_dbg = state;

    // At a rise, cnt holds the number of cycles since the previous rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (clr)         cnt <= '0;
        else if (rise)        cnt <= CNT_W'(1);
        else if (cnt != '1)   cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Timeout wins over an edge arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        latch_hi  = 1'b0;
        timeout   = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) state_nxt = MEAS_HI;
                end
                MEAS_HI: begin
                    if (cnt == TIMEOUT) begin
                        timeout   = 1'b1;
                        state_nxt = IDLE;
                    end else if (fall) begin
                        latch_hi  = 1'b1;
                        state_nxt = MEAS_LO;
                    end
                end
                MEAS_LO: begin
                    if (cnt == TIMEOUT) begin
                        timeout   = 1'b1;
                        state_nxt = IDLE;
                    end else if (rise) begin
                        capture   = 1'b1;
                        state_nxt = MEAS_HI;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            period <= '0;
            high_t <= '0;
            valid  <= 1'b0;
            stuck  <= 1'b0;
        end else if (clr) begin
            hi     <= '0;
            period <= '0;
            high_t <= '0;
            valid  <= 1'b0;
            stuck  <= 1'b0;
        end else begin
            valid <= capture;
            if (latch_hi) hi <= cnt;
            if (capture) begin
                period <= cnt;
                high_t <= hi;
                stuck  <= 1'b0;
            end else if (timeout) begin
                stuck  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: one task per scenario, VALID captures collected by the step driver.
module tb_pwm_capture;

    localparam int          CNT_W   = 16;
    localparam logic [15:0] TIMEOUT = 16'd200;
`ifdef PWM_CAP_FILTER_EN
    localparam int EDGE_LAT = 6;
    localparam int HI_A     = 5;
`else
    localparam int EDGE_LAT = 2;
    localparam int HI_A     = 3;
`endif

    logic             clk, rst_n, pwm_in, clr;
    logic [CNT_W-1:0] period, high_t;
    logic             valid, stuck, level;
    logic [1:0]       state_dbg;

    int errors = 0;
    int checks = 0;
    int b2b    = 0;
    logic prev_valid = 1'b0;

    logic [CNT_W-1:0] got_per[$];
    logic [CNT_W-1:0] got_hi[$];
    logic             got_stk[$];
    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_hi_q[$];

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FILT_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .clr(clr),
        .period(period), .high_t(high_t), .valid(valid), .stuck(stuck),
        .level(level), .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: one clock of PWM_IN, then record any VALID seen
    task automatic step(input logic v);
        pwm_in = v;
        @(posedge clk);
        #1;
        if (valid) begin
            got_per.push_back(period);
            got_hi.push_back(high_t);
            got_stk.push_back(stuck);
            if (prev_valid) b2b++;
        end
        prev_valid = valid;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic drive_pwm(input int p, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            hold(1'b1, h);
            hold(1'b0, p - h);
        end
    endtask

    task automatic clear_got();
        got_per.delete();
        got_hi.delete();
        got_stk.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pwm_in = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (period !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
        checks++; if (high_t !== 16'd0) begin errors++; $display("FAIL reset_high_t: got %0d want 0", high_t); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck: got %b want 0", stuck); end
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b want 0", level); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        rst_n = 1'b1;
        hold(1'b0, 5);
    endtask

    task automatic test_basic();
        clear_got();
        b2b = 0;
        drive_pwm(10, HI_A, 5);
        checks++; if (got_per.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got_per.size()); end
        for (int i = 0; i < got_per.size(); i++) begin
            checks++; if (got_per[i] !== 16'd10) begin errors++; $display("FAIL basic_period[%0d]: got %0d want 10", i, got_per[i]); end
            checks++; if (got_hi[i] !== 16'(HI_A)) begin errors++; $display("FAIL basic_high_t[%0d]: got %0d want %0d", i, got_hi[i], HI_A); end
            checks++; if (got_stk[i] !== 1'b0) begin errors++; $display("FAIL basic_stuck[%0d]: got %b want 0", i, got_stk[i]); end
        end
        checks++; if (b2b !== 0) begin errors++; $display("FAIL basic_back_to_back: got %0d want 0", b2b); end
    endtask

    task automatic test_stuck();
        clear_got();
        hold(1'b0, int'(TIMEOUT) + 10);
        checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL stuck_low_flag: got %b want 1", stuck); end
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL stuck_low_level: got %b want 0", level); end
        hold(1'b1, int'(TIMEOUT) + 10);
        checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL stuck_high_flag: got %b want 1", stuck); end
        checks++; if (level !== 1'b1) begin errors++; $display("FAIL stuck_high_level: got %b want 1", level); end
        checks++; if (period !== 16'd10) begin errors++; $display("FAIL stuck_period_hold: got %0d want 10", period); end
        checks++; if (high_t !== 16'(HI_A)) begin errors++; $display("FAIL stuck_high_t_hold: got %0d want %0d", high_t, HI_A); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL stuck_state: got %0d want 0", state_dbg); end
        checks++; if (got_per.size() !== 0) begin errors++; $display("FAIL stuck_no_valid: got %0d want 0", got_per.size()); end
    endtask

    task automatic test_restart();
        clear_got();
        hold(1'b0, 15);
        drive_pwm(20, 5, 1);
        checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL restart_arm_stuck: got %b want 1", stuck); end
        checks++; if (got_per.size() !== 0) begin errors++; $display("FAIL restart_arm_valid: got %0d want 0", got_per.size()); end
        drive_pwm(20, 5, 2);
        checks++; if (got_per.size() !== 2) begin errors++; $display("FAIL restart_count: got %0d want 2", got_per.size()); end
        for (int i = 0; i < got_per.size(); i++) begin
            checks++; if (got_per[i] !== 16'd20) begin errors++; $display("FAIL restart_period[%0d]: got %0d want 20", i, got_per[i]); end
            checks++; if (got_hi[i] !== 16'd5) begin errors++; $display("FAIL restart_high_t[%0d]: got %0d want 5", i, got_hi[i]); end
            checks++; if (got_stk[i] !== 1'b0) begin errors++; $display("FAIL restart_stuck[%0d]: got %b want 0", i, got_stk[i]); end
        end
    endtask

    task automatic test_clr_on_edge();
        clear_got();
        for (int i = 0; i < 10; i++) begin
            clr = (i == EDGE_LAT);
            step(i < HI_A);
            clr = 1'b0;
            if (i == EDGE_LAT) begin
                checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", valid); end
                checks++; if (period !== 16'd0) begin errors++; $display("FAIL clr_period: got %0d want 0", period); end
                checks++; if (high_t !== 16'd0) begin errors++; $display("FAIL clr_high_t: got %0d want 0", high_t); end
                checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL clr_state: got %0d want 0", state_dbg); end
            end
        end
        drive_pwm(10, HI_A, 1);
        checks++; if (got_per.size() !== 0) begin errors++; $display("FAIL clr_rearm_valid: got %0d want 0", got_per.size()); end
        drive_pwm(10, HI_A, 1);
        checks++; if (got_per.size() !== 1) begin errors++; $display("FAIL clr_next_count: got %0d want 1", got_per.size()); end
        if (got_per.size() > 0) begin
            checks++; if (got_per[0] !== 16'd10) begin errors++; $display("FAIL clr_next_period: got %0d want 10", got_per[0]); end
        end
    endtask

    task automatic test_reset_mid();
        drive_pwm(10, HI_A, 2);
        step(1'b1);
        step(1'b1);
        rst_n = 1'b0;
        #2;
        checks++; if (period !== 16'd0) begin errors++; $display("FAIL rstmid_period: got %0d want 0", period); end
        checks++; if (high_t !== 16'd0) begin errors++; $display("FAIL rstmid_high_t: got %0d want 0", high_t); end
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL rstmid_level: got %b want 0", level); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d want 0", state_dbg); end
        hold(1'b0, 3);
        rst_n = 1'b1;
        hold(1'b0, 5);
        clear_got();
        drive_pwm(10, HI_A, 3);
        checks++; if (got_per.size() !== 2) begin errors++; $display("FAIL rstmid_count: got %0d want 2", got_per.size()); end
        for (int i = 0; i < got_per.size(); i++) begin
            checks++; if (got_per[i] !== 16'd10) begin errors++; $display("FAIL rstmid_period[%0d]: got %0d want 10", i, got_per[i]); end
        end
    endtask

    task automatic test_glitch();
        clr = 1'b1;
        step(1'b0);
        clr = 1'b0;
        hold(1'b0, 5);
        clear_got();
        exp_q.delete();
        exp_hi_q.delete();
`ifdef PWM_CAP_FILTER_EN
        repeat (3) begin exp_q.push_back(16'd100); exp_hi_q.push_back(16'd50); end
`else
        exp_q.push_back(16'd100); exp_hi_q.push_back(16'd50);
        exp_q.push_back(16'd70);  exp_hi_q.push_back(16'd50);
        exp_q.push_back(16'd30);  exp_hi_q.push_back(16'd2);
        exp_q.push_back(16'd100); exp_hi_q.push_back(16'd50);
`endif
        drive_pwm(100, 50, 1);
        hold(1'b1, 50);
        hold(1'b0, 20);
        hold(1'b1, 2);
        hold(1'b0, 28);
        drive_pwm(100, 50, 2);
        checks++; if (got_per.size() !== exp_q.size()) begin errors++; $display("FAIL glitch_count: got %0d want %0d", got_per.size(), exp_q.size()); end
        for (int i = 0; i < got_per.size() && i < exp_q.size(); i++) begin
            checks++; if (got_per[i] !== exp_q[i]) begin errors++; $display("FAIL glitch_period[%0d]: got %0d want %0d", i, got_per[i], exp_q[i]); end
            checks++; if (got_hi[i] !== exp_hi_q[i]) begin errors++; $display("FAIL glitch_high_t[%0d]: got %0d want %0d", i, got_hi[i], exp_hi_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuck();
        test_restart();
        test_clr_on_edge();
        test_reset_mid();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
